// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes / InvSubBytes unit for one 128-bit state.
// LANES bytes are substituted per cycle, so one block takes 16/LANES RUN cycles.
module sub_bytes_engine #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [0:127] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic         busy
);

    localparam int unsigned CYCLES = 16 / LANES;
    localparam int unsigned CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int unsigned LANE_W = 8 * LANES;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Byte b of each table sits at bits [8b:8b+7].
    localparam logic [0:2047] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:2047] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic fwd);
        logic [10:0] idx;
        idx = {b, 3'b000};
        return fwd ? SBOX_FWD[idx +: 8] : SBOX_INV[idx +: 8];
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mode;
    logic [0:127]       r_work;
    logic [0:127]       r_out_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic               w_busy_nxt;
    logic               w_accept;
    logic               w_last;
    logic [6:0]         w_base;
    logic [0:LANE_W-1]  w_win;
    logic [0:LANE_W-1]  w_sub;
    logic [0:127]       w_work_nxt;

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_cnt == CNT_W'(CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state and registered below.
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        case (w_state_nxt)
            ST_IDLE: w_in_ready_nxt = 1'b1;
            ST_RUN:  w_busy_nxt     = 1'b1;
            ST_DONE: begin
                w_out_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            default: w_in_ready_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Lane window for the current counter value; bytes outside it pass through.
    always_comb begin
        w_base     = 7'(r_cnt) * 7'(LANE_W);
        w_win      = r_work[w_base +: LANE_W];
        w_sub      = w_win;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_sub[8*l +: 8] = sub_byte(w_win[8*l +: 8], r_mode);
        end
        w_work_nxt = r_work;
        w_work_nxt[w_base +: LANE_W] = w_sub;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_work      <= '0;
            r_out_state <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_work <= in_state;
                        r_mode <= in_mode;
                        r_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    r_work <= w_work_nxt;
                    r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
                    if (w_last) r_out_state <= w_work_nxt;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine at every legal LANES value, against
// S-box tables derived from GF(2^8) inversion plus the AES affine map.
`timescale 1ns/1ps
module tb_sub_bytes_engine;

    localparam int NI   = 5;
    localparam int N_RT = 1000;

    typedef struct {
        logic [0:127] exp;
        time          t_acc;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit done [NI];

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    function automatic void chk(input string nm, input int lanes,
                                input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s lanes=%0d: got %h expected %h", nm, lanes, act, exp);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [0:127] model(input logic [0:127] s, input logic fwd);
        logic [0:127] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = fwd ? fwd_tab[s[8*k +: 8]] : inv_tab[s[8*k +: 8]];
        return r;
    endfunction

    // S(a) = affine(a^-1) in GF(2^8) mod x^8+x^4+x^3+x+1; inverse table by inversion.
    initial begin
        for (int a = 0; a < 256; a++) begin
            logic [7:0] v, r;
            v = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(a), 8'(c)) == 8'h01) v = 8'(c);
            r = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
            fwd_tab[a] = r;
            inv_tab[r] = 8'(a);
        end
    end

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L   = 1 << gi;
        localparam int CYC = 16 / L;

        logic         rst_n = 1'b0;
        logic         in_valid, in_ready, in_mode, out_valid, out_ready, busy;
        logic [0:127] in_state, out_state;
        item_t        sb [$];

        sub_bytes_engine #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_mode   (in_mode),
            .in_state  (in_state),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_state (out_state),
            .busy      (busy)
        );

        // Called at a negedge; returns at the negedge after acceptance.
        task automatic send(input logic [0:127] s, input logic m,
                            input bit keep, input logic [0:127] exp);
            int  guard;
            time t;
            guard = 0;
            while (in_ready !== 1'b1 && guard < 200) begin
                in_valid = 1'($urandom);
                in_state = {$urandom, $urandom, $urandom, $urandom};
                in_mode  = 1'($urandom);
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) begin
                chk("in_ready_timeout", L, 128'(in_ready), 128'(1));
                in_valid = 1'b0;
                return;
            end
            in_valid = 1'b1;
            in_state = s;
            in_mode  = m;
            @(posedge clk);
            t = $time;
            @(negedge clk);
            in_valid = 1'b0;
            in_mode  = ~m;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            chk("accept_in_ready_low", L, 128'(in_ready), 128'(0));
            chk("accept_busy", L, 128'(busy), 128'(1));
            if (keep) sb.push_back('{exp: exp, t_acc: t});
        endtask

        initial begin : drv
            logic [0:127] s, f;
            in_valid = 1'b0;
            in_mode  = 1'b0;
            in_state = '0;
            repeat (2) @(negedge clk);
            chk("rst_out_valid", L, 128'(out_valid), 128'(0));
            chk("rst_in_ready", L, 128'(in_ready), 128'(1));
            chk("rst_busy", L, 128'(busy), 128'(0));
            chk("rst_out_state", L, out_state, 128'(0));
            rst_n = 1'b1;
            @(negedge clk);

            send(128'h637C777BF26B6FC53001672BFED7AB76, 1'b0, 1'b1, 128'h000102030405060708090A0B0C0D0E0F);
            send(128'h000102030405060708090A0B0C0D0E0F, 1'b1, 1'b1, 128'h637C777BF26B6FC53001672BFED7AB76);
            send({16{8'h53}}, 1'b1, 1'b1, {16{8'hED}});
            send({16{8'h16}}, 1'b0, 1'b1, {16{8'hFF}});

            // Abort a block mid-RUN: no output may appear for it.
            send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, '0);
            repeat ($urandom_range(0, CYC - 1)) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("midrun_rst_out_valid", L, 128'(out_valid), 128'(0));
            chk("midrun_rst_in_ready", L, 128'(in_ready), 128'(1));
            chk("midrun_rst_busy", L, 128'(busy), 128'(0));
            chk("midrun_rst_out_state", L, out_state, 128'(0));
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            send(128'h0, 1'b0, 1'b1, {16{8'h52}});

            for (int i = 0; i < N_RT; i++) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                f = model(s, 1'b1);
                send(s, 1'b1, 1'b1, f);
                send(f, 1'b0, 1'b1, s);
            end

            for (int g = 0; g < 300 && sb.size() != 0; g++) @(negedge clk);
            chk("drain_pending", L, 128'(sb.size()), 128'(0));
            done[gi] = 1'b1;
        end

        initial begin : mon
            bit           prev_v, consumed;
            int           stall, nitem;
            logic [0:127] held;
            item_t        it;
            prev_v = 1'b0; consumed = 1'b0; stall = 0; nitem = 0; held = '0;
            out_ready = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    prev_v   = 1'b0;
                    consumed = 1'b0;
                    continue;
                end
                if (out_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        if (!prev_v) chk("unexpected_out_valid", L, 128'(out_valid), 128'(0));
                        out_ready = 1'b1;
                    end else begin
                        if (!prev_v) begin
                            chk("latency", L, 128'((($time - sb[0].t_acc) - 5) / 10), 128'(CYC));
                            stall = (nitem % 100 == 0) ? 20 : int'($urandom_range(0, 1));
                            held  = out_state;
                        end else begin
                            chk("hold_stable", L, out_state, held);
                        end
                        chk("in_ready_low_while_valid", L, 128'(in_ready), 128'(0));
                        out_ready = (stall == 0);
                        if (stall > 0) stall--;
                        if (out_ready) begin
                            it = sb.pop_front();
                            chk("out_state", L, out_state, it.exp);
                            consumed = 1'b1;
                            nitem++;
                        end
                    end
                end else begin
                    if (consumed) begin
                        chk("in_ready_after_consume", L, 128'(in_ready), 128'(1));
                        chk("busy_after_consume", L, 128'(busy), 128'(0));
                        consumed = 1'b0;
                    end
                    out_ready = 1'($urandom);
                end
                prev_v = (out_valid === 1'b1);
            end
        end
    end

    initial begin : main
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 90000 && !all_done; c++) begin
            @(negedge clk);
            all_done = 1'b1;
            foreach (done[i]) all_done &= done[i];
        end
        chk("global_timeout", 0, 128'(all_done), 128'(1));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
- Parametrised, sequential AES byte-substitution unit for the 128-bit AES state.
- Performs either forward SubBytes or InvSubBytes, selected per transaction, using LANES parallel byte lookups that are iterated over 16/LANES cycles.
- Sits between the AddRoundKey/ShiftRows stages of the iterative cipher/decipher datapath.
- Has valid/ready handshakes on both sides, so area can be traded for throughput.

Parameters:
- LANES, 4, number of byte lookups per cycle. Legal values: 1, 2, 4, 8, 16. Any other value must cause an elaboration error.
- CYCLES, 16/LANES, derived localparam, not overridable. It is the number of substitution cycles per block.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  the source presents a state.
- in_ready  output  1  the engine can accept a state.
- in_mode  input  1  1 = forward SubBytes, 0 = inverse SubBytes. Sampled on acceptance.
- in_state  input  [0:127]  state. Byte k occupies bits [8k:8k+7]. Byte 0 is at bits [0:7].
- out_valid  output  1  the result is available.
- out_ready  input  1  the sink accepts the result.
- out_state  output  [0:127]  substituted state, same byte ordering as in_state.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - FSM = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_state = 0, byte counter = 0, latched mode = 0.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - On in_valid && in_ready: latch in_state into the working register, latch in_mode, clear the counter, go to RUN.
    - in_state is ignored when in_valid = 0.
  - RUN:
    - in_ready = 0.
    - Each cycle, replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register in place with S(byte) or S^-1(byte), according to the latched mode.
    - After the cycle with cnt == CYCLES-1, go to DONE.
    - Counter width is clog2(CYCLES), minimum 1 bit. It wraps to 0 on entry to DONE.
    - When LANES = 16, RUN lasts exactly one cycle.
  - DONE:
    - out_valid = 1 and out_state = working register.
    - out_state holds stable while out_valid = 1 and out_ready = 0, indefinitely (backpressure).
    - On out_ready = 1: go to IDLE. out_valid falls and in_ready rises on the next edge.
    - A new input cannot be accepted in the same cycle as the output is consumed. Inputs are strictly serialised.
- Latency: acceptance at edge T produces out_valid = 1 after edge T+CYCLES. Throughput is one block per CYCLES+2 cycles with out_ready held high.
- Lookup tables: the standard FIPS-197 S-box and its inverse, 256 entries each, purely combinational per lane. Bytes not in the current lane window are unchanged in that cycle.
- Mode change on in_mode while busy has no effect. Only the value latched at acceptance is used.
- out_state retains its last result after returning to IDLE. It is only updated on entry to DONE.
- Reset asserted mid-RUN or mid-DONE:
  - Immediately returns to the reset values.
  - The partial result is discarded and no out_valid pulse is produced.
  - After rst_n deasserts, the first acceptance is possible on the first clk edge.
- No X propagation: all state registers have reset values.

Test Plan:
- Inverse, LANES=4: in_state=0x637C777BF26B6FC53001672BFED7AB76, in_mode=0, out_ready=1 -> out_state=0x000102030405060708090A0B0C0D0E0F with out_valid exactly 4 cycles after acceptance.
- Forward, LANES=1: in_state=0x000102030405060708090A0B0C0D0E0F, in_mode=1 -> out_state=0x637C777BF26B6FC53001672BFED7AB76 after 16 cycles. Also all-0x53 input -> all-0xED.
- Round trip, for each LANES in {1,2,4,8,16}:
  - 1000 random states through forward, then inverse -> original state returned.
  - Measured latency equals 16/LANES.
  - in_ready stays low from acceptance until one cycle after output consumption.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_state stable, in_ready=0 and in_valid pulses ignored. Release -> single handshake, then IDLE.
- Reset mid-RUN (LANES=1, rst_n low at cycle 5) -> out_valid never rises, out_state=0, in_ready=1. The next transaction (all-0x00, inverse) -> all-0x52.
- Mode latch: change in_mode during RUN -> result follows the mode captured at acceptance (all-0x16 inverse -> all-0xFF).
